// File: rtl/ysyx_22041752_axi_arb2_pkg.sv
// Shared widths and FSM encodings for the two-master AXI4 arbiter.
package ysyx_22041752_axi_arb2_pkg;

    localparam int ARB_ID_W   = 4;
    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 64;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rstate_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_XFER = 2'd1,
        W_RESP = 2'd2
    } wstate_e;

endpackage

// File: rtl/ysyx_22041752_rr2.sv
// Two-way round-robin pick: on a tie, the requester that did not win last time gets the grant.
module ysyx_22041752_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt
);

    // combinational pick from the request pair and the previous winner
    always_comb begin
        case (req)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last;
            default: gnt = 1'b0;
        endcase
    end

endmodule

// File: rtl/ysyx_22041752_axi_arb2.sv
// Two-master to one-slave AXI4 arbiter: independent read and write FSMs, grant held for a whole burst.
module ysyx_22041752_axi_arb2
    import ysyx_22041752_axi_arb2_pkg::*;
#(
    parameter int ID_W   = ARB_ID_W,
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic clk,
    input  logic reset,
    input  logic [ID_W-1:0] m0_arid, input logic [ADDR_W-1:0] m0_araddr, input logic [7:0] m0_arlen,
    input  logic [2:0] m0_arsize, input logic [1:0] m0_arburst, input logic m0_arvalid, output logic m0_arready,
    output logic [ID_W-1:0] m0_rid, output logic [DATA_W-1:0] m0_rdata, output logic [1:0] m0_rresp,
    output logic m0_rlast, output logic m0_rvalid, input logic m0_rready,
    input  logic [ID_W-1:0] m0_awid, input logic [ADDR_W-1:0] m0_awaddr, input logic [7:0] m0_awlen,
    input  logic [2:0] m0_awsize, input logic [1:0] m0_awburst, input logic m0_awvalid, output logic m0_awready,
    input  logic [DATA_W-1:0] m0_wdata, input logic [DATA_W/8-1:0] m0_wstrb, input logic m0_wlast,
    input  logic m0_wvalid, output logic m0_wready,
    output logic [ID_W-1:0] m0_bid, output logic [1:0] m0_bresp, output logic m0_bvalid, input logic m0_bready,
    input  logic [ID_W-1:0] m1_arid, input logic [ADDR_W-1:0] m1_araddr, input logic [7:0] m1_arlen,
    input  logic [2:0] m1_arsize, input logic [1:0] m1_arburst, input logic m1_arvalid, output logic m1_arready,
    output logic [ID_W-1:0] m1_rid, output logic [DATA_W-1:0] m1_rdata, output logic [1:0] m1_rresp,
    output logic m1_rlast, output logic m1_rvalid, input logic m1_rready,
    input  logic [ID_W-1:0] m1_awid, input logic [ADDR_W-1:0] m1_awaddr, input logic [7:0] m1_awlen,
    input  logic [2:0] m1_awsize, input logic [1:0] m1_awburst, input logic m1_awvalid, output logic m1_awready,
    input  logic [DATA_W-1:0] m1_wdata, input logic [DATA_W/8-1:0] m1_wstrb, input logic m1_wlast,
    input  logic m1_wvalid, output logic m1_wready,
    output logic [ID_W-1:0] m1_bid, output logic [1:0] m1_bresp, output logic m1_bvalid, input logic m1_bready,
    output logic [ID_W-1:0] s_arid, output logic [ADDR_W-1:0] s_araddr, output logic [7:0] s_arlen,
    output logic [2:0] s_arsize, output logic [1:0] s_arburst, output logic s_arvalid, input logic s_arready,
    input  logic [ID_W-1:0] s_rid, input logic [DATA_W-1:0] s_rdata, input logic [1:0] s_rresp,
    input  logic s_rlast, input logic s_rvalid, output logic s_rready,
    output logic [ID_W-1:0] s_awid, output logic [ADDR_W-1:0] s_awaddr, output logic [7:0] s_awlen,
    output logic [2:0] s_awsize, output logic [1:0] s_awburst, output logic s_awvalid, input logic s_awready,
    output logic [DATA_W-1:0] s_wdata, output logic [DATA_W/8-1:0] s_wstrb, output logic s_wlast,
    output logic s_wvalid, input logic s_wready,
    input  logic [ID_W-1:0] s_bid, input logic [1:0] s_bresp, input logic s_bvalid, output logic s_bready
);

    rstate_e rstate_r, rstate_nxt_s;
    wstate_e wstate_r, wstate_nxt_s;
    logic    rgnt_r, rgnt_nxt_s, rlast_gnt_r, rlast_gnt_nxt_s, rpick_s;
    logic    wgnt_r, wgnt_nxt_s, wlast_gnt_r, wlast_gnt_nxt_s, wpick_s;
    logic    aw_done_r, aw_done_nxt_s, w_done_r, w_done_nxt_s;
    logic    r_addr_s, r_data_s, aw_fwd_s, w_fwd_s, w_resp_s;

    ysyx_22041752_rr2 u_rd_pick (.req({m1_arvalid, m0_arvalid}), .last(rlast_gnt_r), .gnt(rpick_s));
    ysyx_22041752_rr2 u_wr_pick (.req({m1_awvalid, m0_awvalid}), .last(wlast_gnt_r), .gnt(wpick_s));

    // state, grant and flag registers; last-grant resets to 1 so M0 wins the first tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rstate_r    <= R_IDLE;
            rgnt_r      <= 1'b0;
            rlast_gnt_r <= 1'b1;
            wstate_r    <= W_IDLE;
            wgnt_r      <= 1'b0;
            wlast_gnt_r <= 1'b1;
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
        end else begin
            rstate_r    <= rstate_nxt_s;
            rgnt_r      <= rgnt_nxt_s;
            rlast_gnt_r <= rlast_gnt_nxt_s;
            wstate_r    <= wstate_nxt_s;
            wgnt_r      <= wgnt_nxt_s;
            wlast_gnt_r <= wlast_gnt_nxt_s;
            aw_done_r   <= aw_done_nxt_s;
            w_done_r    <= w_done_nxt_s;
        end
    end

    // read FSM next state
    always_comb begin
        rstate_nxt_s    = rstate_r;
        rgnt_nxt_s      = rgnt_r;
        rlast_gnt_nxt_s = rlast_gnt_r;
        case (rstate_r)
            R_IDLE: begin
                if (m0_arvalid | m1_arvalid) begin
                    rstate_nxt_s = R_ADDR;
                    rgnt_nxt_s   = rpick_s;
                end else begin
                    rstate_nxt_s = R_IDLE;
                end
            end
            R_ADDR: begin
                if (s_arvalid & s_arready) rstate_nxt_s = R_DATA;
                else                       rstate_nxt_s = R_ADDR;
            end
            R_DATA: begin
                if (s_rvalid & s_rready & s_rlast) begin
                    rstate_nxt_s    = R_IDLE;
                    rlast_gnt_nxt_s = rgnt_r;
                end else begin
                    rstate_nxt_s = R_DATA;
                end
            end
            default: rstate_nxt_s = R_IDLE;
        endcase
    end

    // write FSM next state; AW and W complete independently, in either order or together
    always_comb begin
        wstate_nxt_s    = wstate_r;
        wgnt_nxt_s      = wgnt_r;
        wlast_gnt_nxt_s = wlast_gnt_r;
        aw_done_nxt_s   = aw_done_r;
        w_done_nxt_s    = w_done_r;
        case (wstate_r)
            W_IDLE: begin
                if (m0_awvalid | m1_awvalid) begin
                    wstate_nxt_s  = W_XFER;
                    wgnt_nxt_s    = wpick_s;
                    aw_done_nxt_s = 1'b0;
                    w_done_nxt_s  = 1'b0;
                end else begin
                    wstate_nxt_s = W_IDLE;
                end
            end
            W_XFER: begin
                aw_done_nxt_s = aw_done_r | (s_awvalid & s_awready);
                w_done_nxt_s  = w_done_r | (s_wvalid & s_wready & s_wlast);
                if (aw_done_nxt_s & w_done_nxt_s) wstate_nxt_s = W_RESP;
                else                              wstate_nxt_s = W_XFER;
            end
            W_RESP: begin
                if (s_bvalid & s_bready) begin
                    wstate_nxt_s    = W_IDLE;
                    wlast_gnt_nxt_s = wgnt_r;
                end else begin
                    wstate_nxt_s = W_RESP;
                end
            end
            default: wstate_nxt_s = W_IDLE;
        endcase
    end

    assign r_addr_s = (rstate_r == R_ADDR);
    assign r_data_s = (rstate_r == R_DATA);
    assign aw_fwd_s = (wstate_r == W_XFER) & ~aw_done_r;
    assign w_fwd_s  = (wstate_r == W_XFER) & ~w_done_r;
    assign w_resp_s = (wstate_r == W_RESP);

    assign s_arid     = rgnt_r ? m1_arid    : m0_arid;
    assign s_araddr   = rgnt_r ? m1_araddr  : m0_araddr;
    assign s_arlen    = rgnt_r ? m1_arlen   : m0_arlen;
    assign s_arsize   = rgnt_r ? m1_arsize  : m0_arsize;
    assign s_arburst  = rgnt_r ? m1_arburst : m0_arburst;
    assign s_arvalid  = r_addr_s & (rgnt_r ? m1_arvalid : m0_arvalid);
    assign m0_arready = r_addr_s & ~rgnt_r & s_arready;
    assign m1_arready = r_addr_s & rgnt_r & s_arready;

    // R payload is broadcast; only the granted master sees rvalid
    assign {m0_rid, m0_rdata, m0_rresp, m0_rlast} = {s_rid, s_rdata, s_rresp, s_rlast};
    assign {m1_rid, m1_rdata, m1_rresp, m1_rlast} = {s_rid, s_rdata, s_rresp, s_rlast};
    assign m0_rvalid = r_data_s & ~rgnt_r & s_rvalid;
    assign m1_rvalid = r_data_s & rgnt_r & s_rvalid;
    assign s_rready  = r_data_s & (rgnt_r ? m1_rready : m0_rready);

    assign s_awid     = wgnt_r ? m1_awid    : m0_awid;
    assign s_awaddr   = wgnt_r ? m1_awaddr  : m0_awaddr;
    assign s_awlen    = wgnt_r ? m1_awlen   : m0_awlen;
    assign s_awsize   = wgnt_r ? m1_awsize  : m0_awsize;
    assign s_awburst  = wgnt_r ? m1_awburst : m0_awburst;
    assign s_awvalid  = aw_fwd_s & (wgnt_r ? m1_awvalid : m0_awvalid);
    assign m0_awready = aw_fwd_s & ~wgnt_r & s_awready;
    assign m1_awready = aw_fwd_s & wgnt_r & s_awready;

    assign s_wdata   = wgnt_r ? m1_wdata : m0_wdata;
    assign s_wstrb   = wgnt_r ? m1_wstrb : m0_wstrb;
    assign s_wlast   = wgnt_r ? m1_wlast : m0_wlast;
    assign s_wvalid  = w_fwd_s & (wgnt_r ? m1_wvalid : m0_wvalid);
    assign m0_wready = w_fwd_s & ~wgnt_r & s_wready;
    assign m1_wready = w_fwd_s & wgnt_r & s_wready;

    assign {m0_bid, m0_bresp} = {s_bid, s_bresp};
    assign {m1_bid, m1_bresp} = {s_bid, s_bresp};
    assign m0_bvalid = w_resp_s & ~wgnt_r & s_bvalid;
    assign m1_bvalid = w_resp_s & wgnt_r & s_bvalid;
    assign s_bready  = w_resp_s & (wgnt_r ? m1_bready : m0_bready);

endmodule
